// File: rtl/keypad_pkg.sv
// +-----------------------------------------------------------------------------
// | keypad_pkg : shared types, key map and pattern decode for keypad_hex_scan
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN      = 2'd0,
      PRESS_DEB = 2'd1,
      HELD      = 2'd2,
      REL_DEB   = 2'd3
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [1:0] idx;
   } onehot_idx_t;

   // Indexed by {row_idx, col_idx}; matches the legend printed on the keypad.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'h0, 4'hF, 4'hE, 4'hD
   };

   // Decodes an active-low pattern; valid only when exactly one bit is low.
   function automatic onehot_idx_t onehot_low_to_idx(input logic [3:0] pattern);
      onehot_idx_t res;
      res = '0;
      case (pattern)
         4'b1110: res = '{valid: 1'b1, idx: 2'd0};
         4'b1101: res = '{valid: 1'b1, idx: 2'd1};
         4'b1011: res = '{valid: 1'b1, idx: 2'd2};
         4'b0111: res = '{valid: 1'b1, idx: 2'd3};
         default: res = '0;
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_hex_scan_sync2.sv
// +-----------------------------------------------------------------------------
// | sync2 : two-flop synchronizer with a selectable reset value
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module sync2 #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/keypad_hex_scan.sv
// +-----------------------------------------------------------------------------
// | keypad_hex_scan : 4x4 matrix keypad column scanner with press/release debounce
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module keypad_hex_scan
   import keypad_pkg::*;
#(
   parameter int CLK_FREQ_HZ      = 12000000,
   parameter int SCAN_HZ          = 1000,
   parameter int DEBOUNCE_TIME_MS = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int SCAN_TICKS = CLK_FREQ_HZ / SCAN_HZ;
   localparam int DEB_TICKS  = (CLK_FREQ_HZ / 1000) * DEBOUNCE_TIME_MS;
   localparam int MAX_TICKS  = (SCAN_TICKS > DEB_TICKS) ? SCAN_TICKS : DEB_TICKS;
   localparam int CNT_W      = $clog2(MAX_TICKS + 1);

   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_TICKS - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_TICKS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   logic [3:0] rs;

   state_t     state_q,    state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0] col_q,      col_d;
   logic [3:0] pat_q,      pat_d;
   logic [3:0] key_code_q, key_code_d;
   logic       key_valid_q, key_valid_d;
   logic       key_held_q, key_held_d;

   logic        rs_idle;
   logic [3:0]  col_next;
   onehot_idx_t row_dec;
   onehot_idx_t col_dec;

   sync2 #(
      .WIDTH     (4),
      .RESET_VAL (4'b1111)
   ) u_row_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (rs)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SCAN;
         cnt_q       <= '0;
         col_q       <= 4'b1110;
         pat_q       <= 4'b1111;
         key_code_q  <= '0;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         col_q       <= col_d;
         pat_q       <= pat_d;
         key_code_q  <= key_code_d;
         key_valid_q <= key_valid_d;
         key_held_q  <= key_held_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      col_d       = col_q;
      pat_d       = pat_q;
      key_code_d  = key_code_q;
      key_valid_d = 1'b0;
      key_held_d  = key_held_q;

      rs_idle  = (rs == 4'b1111);
      col_next = {col_q[2:0], col_q[3]};
      row_dec  = onehot_low_to_idx(pat_q);
      col_dec  = onehot_low_to_idx(col_q);

      case (state_q)
         SCAN: begin
            // Rows are only looked at on the last dwell cycle so the
            // freshly driven column has settled through the synchronizer.
            if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               if (rs_idle) begin
                  col_d = col_next;
               end else begin
                  pat_d   = rs;
                  state_d = PRESS_DEB;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         PRESS_DEB: begin
            if (rs != pat_q) begin
               state_d = SCAN;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               state_d = HELD;
               cnt_d   = '0;
               // Multi-row patterns are ghosts: park in HELD without reporting.
               if (row_dec.valid && col_dec.valid) begin
                  key_code_d  = KEY_MAP[{row_dec.idx, col_dec.idx}];
                  key_valid_d = 1'b1;
                  key_held_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         HELD: begin
            if (rs_idle) begin
               state_d = REL_DEB;
               cnt_d   = '0;
            end
         end

         REL_DEB: begin
            if (!rs_idle) begin
               state_d = HELD;
               cnt_d   = '0;
            end else if (cnt_q == DEB_LAST) begin
               key_held_d = 1'b0;
               col_d      = col_next;
               state_d    = SCAN;
               cnt_d      = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end

         default: begin
            state_d = SCAN;
            cnt_d   = '0;
         end
      endcase
   end

   assign col       = col_q;
   assign key_code  = key_code_q;
   assign key_valid = key_valid_q;
   assign key_held  = key_held_q;

endmodule

`default_nettype wire

// File: tb/tb_keypad_hex_scan.sv
// +-----------------------------------------------------------------------------
// | tb_keypad_hex_scan : keypad matrix model driving keypad_hex_scan, scenario tasks
// | Rev 1.0 - initial release
// +-----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_keypad_hex_scan;

   localparam int SCAN_T    = 10;
   localparam int DEB_T     = 20;
   // Column arrival edge to pulse: full dwell, then the debounce window.
   localparam int PRESS_LAT = SCAN_T + DEB_T;
   // Release to key_held drop: 2 sync flops, 1 edge to leave HELD, then debounce.
   localparam int REL_LAT   = 3 + DEB_T;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;

   logic [15:0] keys = '0;   // bit r*4+c pressed
   int total = 0;
   int bad   = 0;
   int valid_cnt = 0;
   logic [3:0] last_code = '0;

   int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};

   keypad_hex_scan #(
      .CLK_FREQ_HZ      (10000),
      .SCAN_HZ          (1000),
      .DEBOUNCE_TIME_MS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .row       (row),
      .col       (col),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_held  (key_held)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its row low only while its column is driven.
   always_comb begin
      row = 4'b1111;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_valid === 1'b1) begin
         valid_cnt++;
         last_code = key_code;
      end
   end

   function automatic logic [3:0] col_pat(input int c);
      logic [3:0] p;
      p = 4'b1111;
      p[c] = 1'b0;
      return p;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic press_at_arrival(input logic [15:0] k, input int c, output bit ok);
      int n;
      n = 0;
      while (col == col_pat(c) && n < 20) begin step(); n++; end
      keys = k;
      n = 0;
      while (col != col_pat(c) && n < 60) begin step(); n++; end
      ok = (col == col_pat(c));
   endtask

   task automatic release_measure(output int n);
      logic [3:0] c0;
      c0 = col;
      keys = '0;
      n = 0;
      while (col == c0 && n < 100) begin step(); n++; end
   endtask

   task automatic test_reset();
      logic [3:0] exp;
      reset = 1'b1;
      keys  = '0;
      repeat (3) step();
      total++; if (col !== 4'b1110) begin bad++; $display("FAIL reset_col got=%b want=1110", col); end
      total++; if (key_code !== 4'h0) begin bad++; $display("FAIL reset_code got=%h want=0", key_code); end
      total++; if (key_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", key_valid); end
      total++; if (key_held !== 1'b0) begin bad++; $display("FAIL reset_held got=%b want=0", key_held); end
      reset = 1'b0;
      for (int n = 1; n <= 4*SCAN_T; n++) begin
         step();
         exp = col_pat((n / SCAN_T) % 4);
         total++;
         if (col !== exp) begin bad++; $display("FAIL scan_step n=%0d got=%b want=%b", n, col, exp); end
      end
   endtask

   task automatic test_clean_press();
      int v0, n;
      bit ok;
      v0 = valid_cnt;
      press_at_arrival(16'h0001 << 6, 2, ok);
      total++; if (!ok) begin bad++; $display("FAIL clean_arrival got=%b want=%b", col, col_pat(2)); end
      n = 0;
      while (valid_cnt == v0 && n < 100) begin step(); n++; end
      total++; if (n != PRESS_LAT) begin bad++; $display("FAIL clean_latency got=%0d want=%0d", n, PRESS_LAT); end
      total++; if (last_code !== 4'h6) begin bad++; $display("FAIL clean_code got=%h want=6", last_code); end
      total++; if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held got=%b want=1", key_held); end
      repeat (30) step();
      total++; if (col !== 4'b1011) begin bad++; $display("FAIL clean_frozen got=%b want=1011", col); end
      total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL clean_pulses got=%0d want=1", valid_cnt - v0); end
      release_measure(n);
      total++; if (n != REL_LAT) begin bad++; $display("FAIL clean_release_lat got=%0d want=%0d", n, REL_LAT); end
      total++; if (col !== 4'b0111 || key_held !== 1'b0) begin bad++; $display("FAIL clean_release got col=%b held=%b want col=0111 held=0", col, key_held); end
   endtask

   task automatic test_bounce();
      int v0, n;
      v0 = valid_cnt;
      n = 0;
      while (col == col_pat(0) && n < 20) begin step(); n++; end
      for (int i = 0; i < 40; i++) begin
         keys = (((i / 5) % 2) == 0) ? (16'h0001 << 12) : 16'h0000;
         step();
      end
      total++; if (valid_cnt != v0) begin bad++; $display("FAIL bounce_quiet got=%0d want=0 pulses", valid_cnt - v0); end
      keys = 16'h0001 << 12;
      n = 0;
      while (valid_cnt == v0 && n < 150) begin step(); n++; end
      repeat (5) step();
      total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL bounce_pulses got=%0d want=1", valid_cnt - v0); end
      total++; if (last_code !== 4'h0) begin bad++; $display("FAIL bounce_code got=%h want=0", last_code); end
      release_measure(n);
      total++; if (n != REL_LAT || col !== col_pat(1)) begin bad++; $display("FAIL bounce_release got n=%0d col=%b want n=%0d col=%b", n, col, REL_LAT, col_pat(1)); end
   endtask

   task automatic test_release_bounce();
      int v0, n, drops;
      bit ok;
      v0 = valid_cnt;
      drops = 0;
      press_at_arrival(16'h0001 << 15, 3, ok);
      n = 0;
      while (valid_cnt == v0 && n < 100) begin step(); n++; end
      total++; if (!ok || last_code !== 4'hD) begin bad++; $display("FAIL relb_code got=%h want=d", last_code); end
      for (int g = 0; g < 3; g++) begin
         keys = '0;
         repeat (8) begin step(); if (key_held !== 1'b1 || col !== 4'b0111) drops++; end
         keys = 16'h0001 << 15;
         repeat (3) begin step(); if (key_held !== 1'b1 || col !== 4'b0111) drops++; end
      end
      total++; if (drops != 0) begin bad++; $display("FAIL relb_held_glitch got=%0d drops want=0", drops); end
      release_measure(n);
      total++; if (n != REL_LAT) begin bad++; $display("FAIL relb_release_lat got=%0d want=%0d", n, REL_LAT); end
      total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL relb_pulses got=%0d want=1", valid_cnt - v0); end
      total++; if (col !== 4'b1110) begin bad++; $display("FAIL relb_next_col got=%b want=1110", col); end
   endtask

   task automatic test_multi_press();
      int v0, n, errs;
      bit ok;
      v0 = valid_cnt;
      errs = 0;
      press_at_arrival((16'h0001 << 1) | (16'h0001 << 5), 1, ok);
      total++; if (!ok) begin bad++; $display("FAIL multi_arrival got=%b want=1101", col); end
      for (int i = 0; i < 60; i++) begin
         step();
         if (col !== 4'b1101 || key_held !== 1'b0) errs++;
      end
      total++; if (errs != 0) begin bad++; $display("FAIL multi_frozen got=%0d bad cycles want=0", errs); end
      total++; if (valid_cnt != v0) begin bad++; $display("FAIL multi_pulses got=%0d want=0", valid_cnt - v0); end
      total++; if (key_code !== 4'hD) begin bad++; $display("FAIL multi_code got=%h want=d", key_code); end
      release_measure(n);
      total++; if (n != REL_LAT || col !== 4'b1011) begin bad++; $display("FAIL multi_release got n=%0d col=%b want n=%0d col=1011", n, col, REL_LAT); end
   endtask

   task automatic test_reset_mid_press();
      int v0, n;
      bit ok;
      v0 = valid_cnt;
      press_at_arrival(16'h0001 << 10, 2, ok);
      // PRESS_DEB starts at arrival+SCAN_T; its counter holds 15 after 15 more edges.
      repeat (SCAN_T + 15) step();
      reset = 1'b1;
      step();
      total++; if (!ok || col !== 4'b1110) begin bad++; $display("FAIL rmid_col got=%b want=1110", col); end
      total++; if (key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin bad++; $display("FAIL rmid_outputs got code=%h valid=%b held=%b want 0 0 0", key_code, key_valid, key_held); end
      step();
      step();
      reset = 1'b0;
      total++; if (valid_cnt != v0) begin bad++; $display("FAIL rmid_no_pulse got=%0d want=0", valid_cnt - v0); end
      n = 0;
      while (valid_cnt == v0 && n < 200) begin step(); n++; end
      total++; if (valid_cnt - v0 != 1 || last_code !== 4'h9) begin bad++; $display("FAIL rmid_reaccept got pulses=%0d code=%h want 1 9", valid_cnt - v0, last_code); end
      release_measure(n);
      total++; if (n != REL_LAT || col !== 4'b0111) begin bad++; $display("FAIL rmid_release got n=%0d col=%b want n=%0d col=0111", n, col, REL_LAT); end
   endtask

   task automatic test_random();
      int v0, n, k, c, errs;
      bit ok;
      for (int it = 0; it < 8; it++) begin
         k = int'($urandom_range(0, 15));
         c = k % 4;
         repeat ($urandom_range(0, 15)) step();
         v0 = valid_cnt;
         press_at_arrival(16'h0001 << k, c, ok);
         n = 0;
         while (valid_cnt == v0 && n < 100) begin step(); n++; end
         total++; if (!ok || n != PRESS_LAT) begin bad++; $display("FAIL rand_latency key=%0d got=%0d want=%0d", k, n, PRESS_LAT); end
         total++; if (last_code !== 4'(keymap[k])) begin bad++; $display("FAIL rand_code key=%0d got=%h want=%h", k, last_code, 4'(keymap[k])); end
         errs = 0;
         repeat ($urandom_range(1, 25)) begin step(); if (col !== col_pat(c) || key_held !== 1'b1) errs++; end
         total++; if (errs != 0 || valid_cnt - v0 != 1) begin bad++; $display("FAIL rand_hold key=%0d got errs=%0d pulses=%0d want 0 1", k, errs, valid_cnt - v0); end
         release_measure(n);
         total++; if (n != REL_LAT || col !== col_pat((c + 1) % 4) || key_held !== 1'b0) begin bad++; $display("FAIL rand_release key=%0d got n=%0d col=%b want n=%0d col=%b", k, n, col, REL_LAT, col_pat((c + 1) % 4)); end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_release_bounce();
      test_multi_press();
      test_reset_mid_press();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
